// File: rtl/sqrt_dispatch_if.sv
// Handshake bundle between operand source, iterative sqrt core and result consumer.
// master is the environment side (source, core, consumer); slave is the dispatcher.
interface sqrt_dispatch_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) ();
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    logic              core_valid;
    logic [DATA_W-1:0] core_x;
    logic              core_busy;
    logic              core_ready;
    logic [DATA_W-1:0] core_r;

    logic              out_valid;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_r;
    logic              out_ready;

    logic [CntW-1:0]   count;
    logic              err;

    modport master (
        output in_valid, in_data, core_busy, core_ready, core_r, out_ready,
        input  in_ready, core_valid, core_x, out_valid, out_x, out_r, count, err
    );

    modport slave (
        input  in_valid, in_data, core_busy, core_ready, core_r, out_ready,
        output in_ready, core_valid, core_x, out_valid, out_x, out_r, count, err
    );
endinterface

// File: rtl/sqrt_dispatch.sv
// Operand FIFO feeding an iterative sqrt core one launch at a time, with result capture
// onto a valid/ready output port and a sticky timeout error.
module sqrt_dispatch #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic            clk_i,
    input logic            rst_i,
    sqrt_dispatch_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StHold
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   count_d;
    logic              in_ready_q;

    logic              core_valid_q;
    logic [DATA_W-1:0] core_x_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_x_q;
    logic [DATA_W-1:0] out_r_q;
    logic              err_q;
    logic [TmoW-1:0]   tmo_q;

    logic push;
    logic pop;

    assign push = bus.in_valid && in_ready_q;
    // Launch decision; also the only place the FIFO is popped.
    assign pop  = (state_q == StIdle) && (count_q != '0) && !bus.core_busy && !out_valid_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // in_ready is registered so it reads 0 throughout reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != CntW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            core_valid_q <= 1'b0;
            core_x_q     <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_r_q      <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            core_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        core_x_q     <= mem_q[rd_ptr_q];
                        core_valid_q <= 1'b1;
                        state_q      <= StLaunch;
                    end
                end
                StLaunch: begin
                    tmo_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // A ready pulse beats the timeout when both land on the same cycle.
                    if (bus.core_ready) begin
                        out_r_q     <= bus.core_r;
                        out_x_q     <= core_x_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.core_valid = core_valid_q;
    assign bus.core_x     = core_x_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_r      = out_r_q;
    assign bus.count      = count_q;
    assign bus.err        = err_q;

    count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CntW'(DEPTH));

    launch_is_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        core_valid_q |=> !core_valid_q);

    hold_is_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_q && !bus.out_ready) |=>
        (out_valid_q && $stable(out_x_q) && $stable(out_r_q)));
endmodule

// File: tb/tb_sqrt_dispatch.sv
// Randomised bench for sqrt_dispatch with a behavioural floor-sqrt core and an
// in-order expected-result model.
module tb_sqrt_dispatch;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef logic [7:0] u8_q [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Core model knobs, written only by the main sequence.
    int core_lat   = 2;
    bit mute       = 1'b0;
    bit force_busy = 1'b0;

    int  launches = 0;
    u8_q got_x;
    u8_q got_r;

    sqrt_dispatch_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sqrt_dispatch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] isqrt(input logic [7:0] x);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        return 8'(r);
    endfunction

    // Core stand-in: answers core_lat cycles after the launch pulse; not reset by rst.
    initial begin : core_model
        bit         pend;
        int         cnt;
        logic [7:0] cx;
        pend = 1'b0;
        cnt  = 0;
        cx   = '0;
        bus.core_ready = 1'b0;
        bus.core_busy  = 1'b0;
        bus.core_r     = '0;
        forever begin
            @(negedge clk);
            bus.core_ready = 1'b0;
            if (bus.core_valid === 1'b1) begin
                if (!mute) begin
                    pend = 1'b1;
                    cx   = bus.core_x;
                    cnt  = core_lat;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    bus.core_ready = 1'b1;
                    bus.core_r     = isqrt(cx);
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end
            bus.core_busy = pend || force_busy;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_x.push_back(bus.out_x);
            got_r.push_back(bus.out_r);
        end
        if (!rst && bus.core_valid) launches++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        got_x.delete();
        got_r.delete();
        launches = 0;
    endtask

    task automatic send_all(input u8_q ops, output int stalls);
        int  idx = 0;
        bit  acc;
        stalls = 0;
        for (int c = 0; c < 500 && idx < ops.size(); c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ops[idx];
            acc = bus.in_ready;
            if (!acc) stalls++;
            step();
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && got_x.size() < n; i++) step();
        ok = (got_x.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.core_valid !== 1'b0) begin errors++;
            $display("FAIL reset_core_valid: got %b want 0", bus.core_valid); end
        checks++; if (bus.count !== 3'd0) begin errors++;
            $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.err !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++; if (bus.out_x !== 8'd0 || bus.out_r !== 8'd0 || bus.core_x !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: out_x=%0d out_r=%0d core_x=%0d want 0", bus.out_x,
                     bus.out_r, bus.core_x); end
        rst = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
        clear_sb();
    endtask

    task automatic test_single();
        bit ok;
        clear_sb();
        bus.out_ready = 1'b1;
        core_lat = 3;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd16;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.count !== 3'd1) begin errors++;
            $display("FAIL single_count_after_push: got %0d want 1", bus.count); end
        step();
        checks++; if (bus.core_valid !== 1'b1) begin errors++;
            $display("FAIL single_launch_latency: core_valid=%b want 1", bus.core_valid); end
        wait_results(1, 50, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL single_result_timeout: got %0d results want 1", got_x.size()); end
        if (ok) begin
            checks++; if (got_x[0] !== 8'd16 || got_r[0] !== 8'd4) begin errors++;
                $display("FAIL single_result: got x=%0d r=%0d want x=16 r=4", got_x[0],
                         got_r[0]); end
        end
        step();
        step();
        checks++; if (launches != 1 || bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after: launches=%0d count=%0d out_valid=%b want 1/0/0",
                     launches, bus.count, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        u8_q ops;
        u8_q exp_r;
        int  stalls;
        bit  ok;
        clear_sb();
        bus.out_ready = 1'b1;
        core_lat = int'($urandom_range(0, 3));
        ops   = '{8'd0, 8'd1, 8'd255, 8'd100};
        exp_r = '{8'd0, 8'd1, 8'd15, 8'd10};
        send_all(ops, stalls);
        checks++; if (stalls != 0) begin errors++;
            $display("FAIL b2b_in_ready: %0d stall cycles want 0", stalls); end
        wait_results(4, 300, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL b2b_result_timeout: got %0d results want 4", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < 4; i++) begin
            checks++; if (got_x[i] !== ops[i] || got_r[i] !== exp_r[i]) begin errors++;
                $display("FAIL b2b_result[%0d]: got x=%0d r=%0d want x=%0d r=%0d", i,
                         got_x[i], got_r[i], ops[i], exp_r[i]); end
        end
        step();
        checks++; if (bus.count !== 3'd0 || launches != 4) begin errors++;
            $display("FAIL b2b_after: count=%0d launches=%0d want 0/4", bus.count,
                     launches); end
    endtask

    task automatic test_backpressure();
        u8_q ops;
        int  idx = 0;
        bit  acc;
        bit  ok;
        clear_sb();
        bus.out_ready = 1'b0;
        core_lat = 1;
        for (int i = 0; i < 6; i++) ops.push_back(8'($urandom));
        for (int c = 0; c < 30; c++) begin
            bus.in_valid = (idx < 6);
            bus.in_data  = ops[idx < 6 ? idx : 5];
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) idx++;
        end
        checks++; if (idx != 5) begin errors++;
            $display("FAIL bp_accepted: got %0d want 5", idx); end
        checks++; if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_full: count=%0d in_ready=%b want 4/0", bus.count,
                     bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_x !== ops[0] ||
                      bus.out_r !== isqrt(ops[0])) begin errors++;
            $display("FAIL bp_hold: valid=%b x=%0d r=%0d want 1 x=%0d r=%0d", bus.out_valid,
                     bus.out_x, bus.out_r, ops[0], isqrt(ops[0])); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && idx < 6; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ops[idx];
            acc = bus.in_ready;
            step();
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        wait_results(6, 300, ok);
        for (int i = 0; i < 5; i++) step();
        checks++; if (got_x.size() != 6) begin errors++;
            $display("FAIL bp_result_count: got %0d want 6", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < 6; i++) begin
            checks++; if (got_x[i] !== ops[i] || got_r[i] !== isqrt(ops[i])) begin errors++;
                $display("FAIL bp_result[%0d]: got x=%0d r=%0d want x=%0d r=%0d", i,
                         got_x[i], got_r[i], ops[i], isqrt(ops[i])); end
        end
    endtask

    task automatic test_timeout();
        u8_q ops;
        int  stalls;
        int  n = 0;
        bit  ok;
        clear_sb();
        bus.out_ready = 1'b1;
        core_lat = 1;
        mute = 1'b1;
        ops.push_back(8'($urandom));
        ops.push_back(8'($urandom));
        send_all(ops, stalls);
        for (int i = 0; i < 10 && bus.core_valid !== 1'b1; i++) step();
        checks++; if (bus.core_valid !== 1'b1) begin errors++;
            $display("FAIL timeout_launch: core_valid=%b want 1", bus.core_valid); end
        // Let the core model swallow this launch before unmuting it.
        @(negedge clk);
        #1;
        mute = 1'b0;
        do begin
            step();
            n++;
        end while (bus.err !== 1'b1 && n < 100);
        checks++; if (n != TIMEOUT + 1) begin errors++;
            $display("FAIL timeout_cycles: err after %0d cycles want %0d", n, TIMEOUT + 1); end
        checks++; if (got_x.size() != 0) begin errors++;
            $display("FAIL timeout_no_result: got %0d results want 0", got_x.size()); end
        wait_results(1, 100, ok);
        checks++; if (!ok || got_x[0] !== ops[1] || got_r[0] !== isqrt(ops[1])) begin errors++;
            $display("FAIL timeout_next_op: ok=%b want x=%0d r=%0d", ok, ops[1],
                     isqrt(ops[1])); end
        checks++; if (bus.err !== 1'b1) begin errors++;
            $display("FAIL timeout_err_sticky: got %b want 1", bus.err); end
    endtask

    task automatic test_reset_mid();
        u8_q ops;
        int  stalls;
        bit  seen_valid = 1'b0;
        clear_sb();
        bus.out_ready = 1'b1;
        core_lat = 20;
        for (int i = 0; i < 4; i++) ops.push_back(8'($urandom));
        send_all(ops, stalls);
        step();
        checks++; if (bus.count !== 3'd3 || launches != 1) begin errors++;
            $display("FAIL rstmid_queued: count=%0d launches=%0d want 3/1", bus.count,
                     launches); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: count=%0d out_valid=%b err=%b want 0/0/0",
                     bus.count, bus.out_valid, bus.err); end
        clear_sb();
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++; if (seen_valid || launches != 0 || got_x.size() != 0) begin errors++;
            $display("FAIL rstmid_stale_ready: out_valid_seen=%b launches=%0d results=%0d",
                     seen_valid, launches, got_x.size()); end
    endtask

    task automatic test_busy();
        u8_q ops;
        int  stalls;
        bit  ok;
        clear_sb();
        bus.out_ready = 1'b1;
        core_lat = 1;
        force_busy = 1'b1;
        step();
        ops.push_back(8'($urandom));
        ops.push_back(8'($urandom));
        send_all(ops, stalls);
        for (int i = 0; i < 10; i++) step();
        checks++; if (launches != 0 || bus.count !== 3'd2) begin errors++;
            $display("FAIL busy_blocked: launches=%0d count=%0d want 0/2", launches,
                     bus.count); end
        force_busy = 1'b0;
        step();
        checks++; if (bus.core_valid !== 1'b1) begin errors++;
            $display("FAIL busy_release_launch: core_valid=%b want 1", bus.core_valid); end
        wait_results(2, 100, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL busy_results: got %0d want 2", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < 2; i++) begin
            checks++; if (got_x[i] !== ops[i] || got_r[i] !== isqrt(ops[i])) begin errors++;
                $display("FAIL busy_result[%0d]: got x=%0d r=%0d want x=%0d r=%0d", i,
                         got_x[i], got_r[i], ops[i], isqrt(ops[i])); end
        end
    endtask

    task automatic test_random();
        u8_q        ops;
        int         idx = 0;
        bit         acc;
        bit         hold;
        logic [7:0] px;
        logic [7:0] pr;
        clear_sb();
        core_lat = int'($urandom_range(0, 4));
        for (int i = 0; i < 16; i++) ops.push_back(8'($urandom));
        for (int c = 0; c < 3000 && (idx < 16 || got_x.size() < 16); c++) begin
            bus.in_valid  = (idx < 16) && ($urandom_range(0, 1) == 1);
            bus.in_data   = ops[idx < 16 ? idx : 15];
            bus.out_ready = ($urandom_range(0, 2) != 0);
            acc  = bus.in_valid && bus.in_ready;
            hold = bus.out_valid && !bus.out_ready;
            px   = bus.out_x;
            pr   = bus.out_r;
            step();
            if (acc) idx++;
            if (hold) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_x !== px || bus.out_r !== pr)
                begin errors++;
                    $display("FAIL rand_hold_stable: valid=%b x=%0d r=%0d want 1 x=%0d r=%0d",
                             bus.out_valid, bus.out_x, bus.out_r, px, pr); end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (got_x.size() != 16) begin errors++;
            $display("FAIL rand_result_count: got %0d want 16", got_x.size()); end
        for (int i = 0; i < got_x.size() && i < 16; i++) begin
            checks++; if (got_x[i] !== ops[i] || got_r[i] !== isqrt(ops[i])) begin errors++;
                $display("FAIL rand_result[%0d]: got x=%0d r=%0d want x=%0d r=%0d", i,
                         got_x[i], got_r[i], ops[i], isqrt(ops[i])); end
        end
    endtask

    initial begin : main
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
